// File: rtl/id_ex_pkg.sv
// Shared widths, carried-field bundle and NOP control encodings for the ID/EX stage.
package id_ex_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned WB_W   = 2;
  localparam int unsigned M_W    = 3;
  localparam int unsigned EX_W   = 4;

  typedef struct packed {
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] sext;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [WB_W-1:0]   wb_ctl;
    logic [M_W-1:0]    m_ctl;
    logic [EX_W-1:0]   ex_ctl;
  } id_ex_bundle_t;

  localparam logic [WB_W-1:0] WB_NOP = '0;
  localparam logic [M_W-1:0]  M_NOP  = '0;
  localparam logic [EX_W-1:0] EX_NOP = '0;

endpackage

// File: rtl/id_ex_slot.sv
// One bundle register with a valid bit. kill has priority and forces the low CTL_W
// control bits to the NOP pattern while the data bits hold.
module id_ex_slot #(
  parameter int unsigned     W      = 8,
  parameter int unsigned     CTL_W  = 1,
  parameter logic [CTL_W-1:0] CtlNop = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         kill_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (kill_i) begin
      valid_d            = 1'b0;
      data_d[CTL_W-1:0]  = CtlNop;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush-to-bubble and bubble counter.
// Define ID_EX_PIPE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module id_ex_pipe_stage #(
  parameter int unsigned DATA_W = id_ex_pkg::DATA_W,
  parameter int unsigned REG_W  = id_ex_pkg::REG_W,
  parameter int unsigned WB_W   = id_ex_pkg::WB_W,
  parameter int unsigned M_W    = id_ex_pkg::M_W,
  parameter int unsigned EX_W   = id_ex_pkg::EX_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] sext,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [WB_W-1:0]   wb_ctl,
  input  logic [M_W-1:0]    m_ctl,
  input  logic [EX_W-1:0]   ex_ctl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] npc_q,
  output logic [DATA_W-1:0] rdata1_q,
  output logic [DATA_W-1:0] rdata2_q,
  output logic [DATA_W-1:0] sext_q,
  output logic [REG_W-1:0]  rt_q,
  output logic [REG_W-1:0]  rd_q,
  output logic [WB_W-1:0]   wb_ctl_q,
  output logic [M_W-1:0]    m_ctl_q,
  output logic [EX_W-1:0]   ex_ctl_q,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned CtlW    = WB_W + M_W + EX_W;
  localparam int unsigned BundleW = 4 * DATA_W + 2 * REG_W + CtlW;
  localparam logic [CtlW-1:0] CtlNop = {WB_W'(id_ex_pkg::WB_NOP), M_W'(id_ex_pkg::M_NOP),
                                        EX_W'(id_ex_pkg::EX_NOP)};

  logic [BundleW-1:0] in_bundle, main_din, main_data;
  logic               in_xfer, out_xfer, main_load, main_drain;
  logic [1:0]         squash_n;
  logic [CNT_W+1:0]   cnt_sum;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Control groups sit in the low bits so a slot kill zeroes exactly them.
  assign in_bundle = {npc, rdata1, rdata2, sext, rt, rd, wb_ctl, m_ctl, ex_ctl};
  assign {npc_q, rdata1_q, rdata2_q, sext_q, rt_q, rd_q, wb_ctl_q, m_ctl_q, ex_ctl_q} = main_data;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef ID_EX_PIPE_SKID_EN
  logic               skid_valid, skid_load, skid_drain, main_free;
  logic [BundleW-1:0] skid_data;

  assign in_ready = !skid_valid;

  // Skid only fills while main is stalled, so a free main with skid valid never sees input.
  always_comb begin
    main_free  = !out_valid || out_ready;
    main_load  = 1'b0;
    main_drain = 1'b0;
    main_din   = in_bundle;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (main_free) begin
      if (skid_valid) begin
        main_load  = 1'b1;
        main_din   = skid_data;
        skid_drain = 1'b1;
      end else if (in_xfer) begin
        main_load = 1'b1;
      end else begin
        main_drain = out_xfer;
      end
    end else begin
      skid_load = in_xfer;
    end
  end

  assign squash_n = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, in_xfer};

  id_ex_slot #(
    .W      (BundleW),
    .CTL_W  (CtlW),
    .CtlNop (CtlNop)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .kill_i  (flush),
    .data_i  (in_bundle),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );
`else
  assign in_ready   = !out_valid || out_ready;
  assign main_load  = in_xfer;
  assign main_drain = out_xfer;
  assign main_din   = in_bundle;
  assign squash_n   = {1'b0, out_valid || in_xfer};
`endif

  id_ex_slot #(
    .W      (BundleW),
    .CTL_W  (CtlW),
    .CtlNop (CtlNop)
  ) u_main (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (main_load),
    .drain_i (main_drain),
    .kill_i  (flush),
    .data_i  (main_din),
    .valid_o (out_valid),
    .data_o  (main_data)
  );

  always_comb begin
    cnt_sum = {2'b00, cnt_q} + {{CNT_W{1'b0}}, squash_n};
    cnt_d   = cnt_q;
    if (flush) begin
      cnt_d = (cnt_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: queue-based reference model checked every negedge plus
// directed literal checks. Follows ID_EX_PIPE_SKID_EN when defined.
module tb_id_ex_pipe_stage;
  import id_ex_pkg::*;

  localparam int unsigned TbCntW = 2;
  localparam int          CntMax = (1 << TbCntW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  id_ex_bundle_t din = '0;
  id_ex_bundle_t dut_b;
  logic [DATA_W-1:0] npc_q, rdata1_q, rdata2_q, sext_q;
  logic [REG_W-1:0]  rt_q, rd_q;
  logic [WB_W-1:0]   wb_ctl_q;
  logic [M_W-1:0]    m_ctl_q;
  logic [EX_W-1:0]   ex_ctl_q;
  logic [TbCntW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: beats held in the stage, the bundle last shown, squash count.
  id_ex_bundle_t q[$];
  id_ex_bundle_t shown = '0;
  int            m_cnt = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(
    .CNT_W (TbCntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .npc        (din.npc),
    .rdata1     (din.rdata1),
    .rdata2     (din.rdata2),
    .sext       (din.sext),
    .rt         (din.rt),
    .rd         (din.rd),
    .wb_ctl     (din.wb_ctl),
    .m_ctl      (din.m_ctl),
    .ex_ctl     (din.ex_ctl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .npc_q      (npc_q),
    .rdata1_q   (rdata1_q),
    .rdata2_q   (rdata2_q),
    .sext_q     (sext_q),
    .rt_q       (rt_q),
    .rd_q       (rd_q),
    .wb_ctl_q   (wb_ctl_q),
    .m_ctl_q    (m_ctl_q),
    .ex_ctl_q   (ex_ctl_q),
    .bubble_cnt (bubble_cnt)
  );

  assign dut_b = {npc_q, rdata1_q, rdata2_q, sext_q, rt_q, rd_q, wb_ctl_q, m_ctl_q, ex_ctl_q};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_in_ready();
`ifdef ID_EX_PIPE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      shown = '0;
      m_cnt = 0;
    end else begin
      automatic logic in_x = in_valid && model_in_ready();
      automatic int   squashed = q.size() + (in_x ? 1 : 0);
      if (flush) begin
`ifndef ID_EX_PIPE_SKID_EN
        if (squashed > 1) squashed = 1;
`endif
        m_cnt += squashed;
        if (m_cnt > CntMax) m_cnt = CntMax;
        q.delete();
        shown.wb_ctl = '0;
        shown.m_ctl  = '0;
        shown.ex_ctl = '0;
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_x) q.push_back(din);
        if (q.size() > 0) shown = q[0];
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 256'(out_valid), 256'(q.size() > 0));
    chk("in_ready", 256'(in_ready), 256'(model_in_ready()));
    chk("bundle", 256'(dut_b), 256'(shown));
    chk("bubble_cnt", 256'(bubble_cnt), 256'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_bundle", 256'(dut_b), 256'(0));
    chk("rst_bubble_cnt", 256'(bubble_cnt), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset asserted between edges while a beat is loaded
    din.npc = 32'h0000_0004;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    chk("load_npc", 256'(npc_q), 256'(32'h4));
    chk("load_valid", 256'(out_valid), 256'(1));
    in_valid = 1'b0;
    pulse_reset();

    // Streaming four beats
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din.npc = 32'h10 + 32'(4 * i);
      din.rt  = 5'(i + 1);
      step();
      chk("stream_npc", 256'(npc_q), 256'(32'h10 + 32'(4 * i)));
      chk("stream_valid", 256'(out_valid), 256'(1));
      chk("stream_ready", 256'(in_ready), 256'(1));
    end

    // Stall holds rdata1 and blocks input
    din.rdata1 = 32'hDEAD_BEEF;
    step();
    out_ready = 1'b0;
    din.rdata1 = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rdata1", 256'(rdata1_q), 256'(32'hDEAD_BEEF));
`ifndef ID_EX_PIPE_SKID_EN
      chk("stall_in_ready", 256'(in_ready), 256'(0));
`endif
    end
    out_ready = 1'b1;
    step();
    chk("release_rdata1", 256'(rdata1_q), 256'(32'h1111_1111));
    in_valid = 1'b0;
    step();
    step();

    // Flush a valid stage, then flush the empty stage
    din.npc = 32'h30;
    din.ex_ctl = 4'b1010;
    din.wb_ctl = 2'b11;
    din.m_ctl  = 3'b101;
    in_valid = 1'b1;
    step();
    chk("pre_flush_ex", 256'(ex_ctl_q), 256'(4'b1010));
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    chk("flush_valid", 256'(out_valid), 256'(0));
    chk("flush_ctl", 256'({wb_ctl_q, m_ctl_q, ex_ctl_q}), 256'(0));
    chk("flush_npc_hold", 256'(npc_q), 256'(32'h30));
    chk("flush_cnt1", 256'(bubble_cnt), 256'(1));
    step();
    chk("flush_empty_cnt", 256'(bubble_cnt), 256'(1));

    // Flush with simultaneous input: beat discarded but counted
    din.npc = 32'h40;
    in_valid = 1'b1;
    step();
    chk("flush_in_valid", 256'(out_valid), 256'(0));
    chk("flush_in_npc", 256'(npc_q), 256'(32'h30));
    chk("flush_in_cnt", 256'(bubble_cnt), 256'(2));

    // Saturation at 3
    for (int i = 0; i < 5; i++) step();
    chk("sat_cnt", 256'(bubble_cnt), 256'(3));
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();

`ifdef ID_EX_PIPE_SKID_EN
    pulse_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    din.npc = 32'h20;
    step();
    chk("skid_ready1", 256'(in_ready), 256'(1));
    chk("skid_npc1", 256'(npc_q), 256'(32'h20));
    din.npc = 32'h24;
    step();
    chk("skid_ready2", 256'(in_ready), 256'(0));
    chk("skid_npc2", 256'(npc_q), 256'(32'h20));
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("skid_order", 256'(npc_q), 256'(32'h24));
    chk("skid_order_valid", 256'(out_valid), 256'(1));
    step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    din.npc = 32'h28;
    step();
    din.npc = 32'h2C;
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    chk("skid_flush_cnt", 256'(bubble_cnt), 256'(2));
    chk("skid_flush_valid", 256'(out_valid), 256'(0));
    flush = 1'b0;
    step();
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised ID/EX pipeline stage between the decode and execute stages of the MIPS datapath.
- Carries NPC, both register-read operands, the sign-extended immediate, rt/rd indices and the WB/M/EX control groups.
- Adds a valid/ready handshake (stall back-pressure), a synchronous flush that inserts a bubble, and a saturating bubble counter.

Parameters:
- DATA_W, 32: width of npc, rdata1, rdata2, sext.
- REG_W, 5: width of the rt/rd register indices.
- WB_W, 2: width of the WB control group.
- M_W, 3: width of the MEM control group.
- EX_W, 4: width of the EX control group.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode stage presents a beat.
- in_ready  out  1  stage accepts the beat this cycle.
- flush  in  1  squash stage contents; insert a bubble.
- npc, rdata1, rdata2, sext  in  DATA_W each  decode data fields.
- rt, rd  in  REG_W each  register indices (instr[20:16], instr[15:11]).
- wb_ctl, m_ctl, ex_ctl  in  WB_W / M_W / EX_W  control groups.
- out_valid  out  1  execute-side beat valid.
- out_ready  in  1  execute stage consumes the beat.
- npc_q, rdata1_q, rdata2_q, sext_q  out  DATA_W each  registered data fields.
- rt_q, rd_q  out  REG_W each  registered register indices.
- wb_ctl_q, m_ctl_q, ex_ctl_q  out  WB_W / M_W / EX_W  registered control groups.
- bubble_cnt  out  CNT_W  count of flush-inserted bubbles.

Behaviour:
- Reset (async, reset=1): all outputs and internal state go to 0.
  - out_valid=0, every *_q=0, bubble_cnt=0.
  - in_ready follows its combinational rule against the cleared state; it is 1 in the base build.
- Transfer rules:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Base build: in_ready = !out_valid || out_ready (combinational).
- Load on input transfer, flush=0:
  - All *_q take the inputs and out_valid<=1.
  - Latency is 1 cycle.
- Output transfer with no input transfer: out_valid<=0; data fields hold their values.
- Stall (out_valid && !out_ready): all *_q hold and in_ready=0.
- flush=1 has top priority at the edge:
  - out_valid<=0.
  - wb_ctl_q, m_ctl_q and ex_ctl_q <= 0, so any glitch propagates as a NOP.
  - Data fields hold.
  - A simultaneous input transfer is discarded; upstream treats it as consumed.
- bubble_cnt:
  - Increments by 1 on each flush edge where out_valid was 1 or an input transfer occurred, i.e. a real instruction was squashed.
  - Flush of an empty stage does not count.
  - Saturates at 2^CNT_W-1 with no wrap.
- Simultaneous input and output transfer: back-to-back throughput of 1 beat/cycle with no bubble.
- Reset asserted mid-stall or mid-flush overrides everything, asynchronously.
- Control fields of an invalid stage: whatever was last loaded, or 0 after a flush/reset.
  - Consumers must qualify with out_valid.
  - The flush zeroing guarantees safety for legacy consumers that ignore out_valid.

Optional Feature:
- Macro: ID_EX_PIPE_SKID_EN.
- Defined:
  - A one-entry skid register is added and in_ready becomes a registered signal: in_ready = !skid_full.
  - A beat accepted while the main stage is stalled goes to skid. When the stage drains, skid moves to main in the same edge and skid_full<=0.
  - Ordering is preserved.
  - Flush clears main and skid valid bits. bubble_cnt adds the number of valid entries squashed (0..2, plus an accepted input), saturating.
  - Throughput remains 1 beat/cycle.
- Not defined: base combinational in_ready as above; no skid storage.

Decomposition:
- Shared package id_ex_pkg holds:
  - Default width constants (DATA_W, REG_W, WB_W, M_W, EX_W).
  - A packed struct id_ex_bundle_t grouping all carried fields.
  - The NOP control constants (all-zero WB/M/EX).
- One natural sub-module, id_ex_slot:
  - A single bundle register with valid bit, load and clear-control inputs.
  - Instantiated once for main and once for skid under ID_EX_PIPE_SKID_EN.

Test Plan:
- Reset mid-load: drive npc=0x00000004, in_valid=1, assert reset between edges -> out_valid=0, all *_q=0, bubble_cnt=0 immediately (asynchronous).
- Streaming, out_ready=1: 4 beats with npc=0x10, 0x14, 0x18, 0x1C -> each appears on npc_q one cycle later, out_valid held 1, in_ready held 1.
- Stall:
  - Load rdata1=0xDEADBEEF, then out_ready=0 for 3 cycles -> rdata1_q holds, in_ready=0 (base build).
  - Release -> next beat loads on the following edge.
- Flush with valid stage: stage holds ex_ctl_q=4'b1010, assert flush -> out_valid=0, wb/m/ex_ctl_q=0, bubble_cnt 0->1.
  - Flush again on the empty stage -> bubble_cnt stays 1.
- Flush with simultaneous input: in_valid=1, npc=0x40 -> beat discarded, out_valid=0, npc_q unchanged.
- Counter saturation (CNT_W=2): 5 squashing flushes -> bubble_cnt=3.
- With ID_EX_PIPE_SKID_EN:
  - Stall with 2 beats (0x20, 0x24) -> in_ready falls only after the second beat; release -> 0x20 then 0x24 in order.
  - Flush with both entries valid -> bubble_cnt += 2.
